gcd_scheduler: RTL

- Round-robin scheduler that shares one iterative subtraction-based gcd engine between N requesters.
- Accepts operand pairs on per-requester valid/ready handshakes and sequences the engine's load/compute protocol.
  - Load phase: engine reset input low, so it captures its operands.
  - Compute phase: engine reset input high until it raises ready.
- Returns the result to the granted requester on a per-requester response handshake.
- Includes a watchdog so a stuck engine cannot block the shared resource.

---
 rtl/gcd_scheduler_if.sv | 45 ++++
 rtl/gcd_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/gcd_scheduler_if.sv
// ============================================================================
// Module : gcd_scheduler_if
// Bundles the requester, response and engine signals of gcd_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gcd_scheduler_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           eng_go;
  logic [W-1:0]   eng_xi;
  logic [W-1:0]   eng_yi;
  logic [W-1:0]   eng_xo;
  logic           eng_rdy;
  logic           busy;
  logic [GW-1:0]  grant_id;

  // Scheduler side
  modport master (
    input  req_valid, req_x, req_y, resp_ready, eng_xo, eng_rdy,
    output req_ready, resp_valid, resp_data, resp_err,
           eng_go, eng_xi, eng_yi, busy, grant_id
  );

  // Requesters and engine side
  modport slave (
    output req_valid, req_x, req_y, resp_ready, eng_xo, eng_rdy,
    input  req_ready, resp_valid, resp_data, resp_err,
           eng_go, eng_xi, eng_yi, busy, grant_id
  );
endinterface

`default_nettype wire

// File: rtl/gcd_scheduler.sv
// ============================================================================
// Module : gcd_scheduler
// Round-robin sharing of one iterative gcd engine between N requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd_scheduler #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 131071,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  gcd_scheduler_if.master bus
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] last_q,  last_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [W-1:0]  xi_q,    xi_d;
  logic [W-1:0]  yi_q,    yi_d;
  logic [W-1:0]  data_q,  data_d;
  logic          err_q,   err_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;

  // Scan downwards so the requester nearest after last_q is assigned last and wins
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N;
      if (bus.req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    xi_d    = xi_q;
    yi_d    = yi_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          xi_d    = bus.req_x[int'(pick_idx)*W +: W];
          yi_d    = bus.req_y[int'(pick_idx)*W +: W];
          grant_d = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Engine completion wins over a watchdog expiry in the same cycle
        if (bus.eng_rdy) begin
          data_d  = bus.eng_xo;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= GW'(N - 1);
      grant_q <= '0;
      xi_q    <= '0;
      yi_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      xi_q    <= xi_d;
      yi_q    <= yi_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE && pick_valid) ? (N'(1) << pick_idx) : '0;
  assign bus.resp_valid = (state_q == S_RESP) ? (N'(1) << grant_q) : '0;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign bus.eng_go     = (state_q == S_RUN);
  assign bus.eng_xi     = xi_q;
  assign bus.eng_yi     = yi_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.grant_id   = grant_q;

endmodule

`default_nettype wire
